// File: rtl/bp_be_pkg.sv
// Shared types and helpers for the backend stride-prefetch controller.
package bp_be_pkg;

  localparam int unsigned bp_be_vaddr_width_gp = 39;

  typedef enum logic {
    e_idle  = 1'b0,
    e_issue = 1'b1
  } bp_be_pf_state_e;

  typedef struct packed {
    logic [bp_be_vaddr_width_gp-1:0] pc;
    logic [bp_be_vaddr_width_gp-1:0] eaddr;
  } bp_be_train_req_s;

  // Byte-offset bits inside one dcache line of line_width bits.
  function automatic int unsigned line_offset_width(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  localparam int unsigned bp_be_line_offset_width_gp = line_offset_width(512);

endpackage

// File: rtl/bp_be_pf_rr_arb2.sv
// Two-input round-robin arbiter; on contention the port not granted last wins.
module bp_be_pf_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [1:0] v_i,
  output logic [1:0] grant_o
);

  // High when port 1 holds priority on contention; reset favours port 0.
  logic       r_prio1;
  logic [1:0] w_grant;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_grant = 2'b00;
    if (en_i) begin
      if (v_i == 2'b11) w_grant = r_prio1 ? 2'b10 : 2'b01;
      else              w_grant = v_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)      r_prio1 <= 1'b0;
    else if (w_grant[0]) r_prio1 <= 1'b1;
    else if (w_grant[1]) r_prio1 <= 1'b0;
  end

  assign grant_o = w_grant;

endmodule

// File: rtl/bp_be_stride_prefetch_ctrl.sv
// Arbitrates load training into the RPT, aligns stride reports with their
// effective address and issues a line-deduplicated prefetch burst.
module bp_be_stride_prefetch_ctrl
  import bp_be_pkg::*;
#(
  parameter int unsigned vaddr_width_p     = bp_be_vaddr_width_gp,
  parameter int unsigned stride_width_p    = 8,
  parameter int unsigned prefetch_degree_p = 2,
  parameter int unsigned line_width_p      = 512,
  parameter int unsigned rpt_latency_p     = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      train0_v_i,
  input  logic [vaddr_width_p-1:0]  train0_pc_i,
  input  logic [vaddr_width_p-1:0]  train0_eaddr_i,
  output logic                      train0_ready_o,
  input  logic                      train1_v_i,
  input  logic [vaddr_width_p-1:0]  train1_pc_i,
  input  logic [vaddr_width_p-1:0]  train1_eaddr_i,
  output logic                      train1_ready_o,
  input  logic                      rpt_init_done_i,
  output logic                      rpt_w_v_o,
  output logic [vaddr_width_p-1:0]  rpt_pc_o,
  output logic [vaddr_width_p-1:0]  rpt_eff_addr_o,
  input  logic                      rpt_stride_v_i,
  input  logic [stride_width_p-1:0] rpt_stride_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_i,
  output logic                      busy_o,
  output logic [7:0]                drop_cnt_o
);

  localparam int unsigned off_lp   = line_offset_width(line_width_p);
  localparam int unsigned line_w_lp = vaddr_width_p - off_lp;
  localparam int unsigned rem_w_lp  = $clog2(prefetch_degree_p + 1);

  logic [1:0]        w_grant;
  bp_be_train_req_s  w_win;

  // Reset also masks grants so the RPT strobe is quiet while reset is held.
  bp_be_pf_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (rpt_init_done_i & reset_n_i),
    .v_i       ({train1_v_i, train0_v_i}),
    .grant_o   (w_grant)
  );

  always_comb begin
    w_win = '0;
    if (w_grant[0])      w_win = '{pc: train0_pc_i, eaddr: train0_eaddr_i};
    else if (w_grant[1]) w_win = '{pc: train1_pc_i, eaddr: train1_eaddr_i};
  end

  assign train0_ready_o = w_grant[0];
  assign train1_ready_o = w_grant[1];
  assign rpt_w_v_o      = |w_grant;
  assign rpt_pc_o       = w_win.pc;
  assign rpt_eff_addr_o = w_win.eaddr;

  // Shadow pipe: entry 0 is the newest grant, the tail lines up with the RPT report.
  logic [rpt_latency_p-1:0]                    r_sh_v;
  logic [rpt_latency_p-1:0][vaddr_width_p-1:0] r_sh_eaddr;

  // NOTE: the shadow entries are reset because their valid bits gate report acceptance.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sh_v     <= '0;
      r_sh_eaddr <= '0;
    end else if (flush_i) begin
      r_sh_v     <= '0;
      r_sh_eaddr <= '0;
    end else begin
      r_sh_v[0]     <= |w_grant;
      r_sh_eaddr[0] <= w_win.eaddr;
      for (int i = 1; i < rpt_latency_p; i++) begin
        r_sh_v[i]     <= r_sh_v[i-1];
        r_sh_eaddr[i] <= r_sh_eaddr[i-1];
      end
    end
  end

  logic                     w_tail_v;
  logic [vaddr_width_p-1:0] w_tail_eaddr;
  logic [vaddr_width_p-1:0] w_stride_ext;
  logic                     w_report_ok;

  assign w_tail_v     = r_sh_v[rpt_latency_p-1];
  assign w_tail_eaddr = r_sh_eaddr[rpt_latency_p-1];
  assign w_stride_ext = {{(vaddr_width_p-stride_width_p){rpt_stride_i[stride_width_p-1]}},
                         rpt_stride_i};
  assign w_report_ok  = rpt_stride_v_i & w_tail_v & (rpt_stride_i != '0) & ~flush_i;

  bp_be_pf_state_e          r_state,     w_state_n;
  logic [vaddr_width_p-1:0] r_base,      w_base_n;
  logic [vaddr_width_p-1:0] r_stride,    w_stride_n;
  logic [rem_w_lp-1:0]      r_rem,       w_rem_n;
  logic [line_w_lp-1:0]     r_last_line, w_last_line_n;
  logic                     r_last_v,    w_last_v_n;
  logic [7:0]               r_drop_cnt,  w_drop_cnt_n;
  logic                     w_skip;
  logic                     w_pf_v;

  assign w_skip = (r_state == e_issue) & r_last_v
                & (r_base[vaddr_width_p-1:off_lp] == r_last_line);

  always_comb begin
    w_state_n     = r_state;
    w_base_n      = r_base;
    w_stride_n    = r_stride;
    w_rem_n       = r_rem;
    w_last_line_n = r_last_line;
    w_last_v_n    = r_last_v;
    w_drop_cnt_n  = r_drop_cnt;
    w_pf_v        = 1'b0;
    unique case (r_state)
      e_idle: begin
        if (w_report_ok) begin
          w_base_n   = w_tail_eaddr + w_stride_ext;
          w_stride_n = w_stride_ext;
          w_rem_n    = rem_w_lp'(prefetch_degree_p);
          w_state_n  = e_issue;
        end
      end
      e_issue: begin
        w_pf_v = ~w_skip;
        if (w_report_ok && (r_drop_cnt != 8'hFF)) w_drop_cnt_n = r_drop_cnt + 8'd1;
        // A same-line target retires silently; otherwise it waits for the handshake.
        if (w_skip || pf_ready_i) begin
          if (!w_skip) begin
            w_last_line_n = r_base[vaddr_width_p-1:off_lp];
            w_last_v_n    = 1'b1;
          end
          w_base_n = r_base + r_stride;
          w_rem_n  = r_rem - rem_w_lp'(1);
          if (r_rem == rem_w_lp'(1)) w_state_n = e_idle;
        end
        if (flush_i) w_state_n = e_idle;
      end
      default: w_state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_idle;
      r_base      <= '0;
      r_stride    <= '0;
      r_rem       <= '0;
      r_last_line <= '0;
      r_last_v    <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_n;
      r_base      <= w_base_n;
      r_stride    <= w_stride_n;
      r_rem       <= w_rem_n;
      r_last_line <= w_last_line_n;
      r_last_v    <= w_last_v_n;
      r_drop_cnt  <= w_drop_cnt_n;
    end
  end

  assign pf_v_o     = w_pf_v;
  assign pf_addr_o  = w_pf_v ? r_base : '0;
  assign busy_o     = (r_state == e_issue);
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/bp_be_stride_prefetch_ctrl.md
Name: bp_be_stride_prefetch_ctrl

Overview:
Controller sitting between the backend load pipes, the load-stride reference prediction table (RPT) and the dcache prefetch port. It arbitrates two load-training streams round-robin into the single-ported RPT, gating training until the RPT finishes initialization. It aligns each RPT stride report with the effective address that produced it, then sequences a burst of `prefetch_degree_p` line-deduplicated prefetch requests over a valid/ready handshake.

Parameters:
vaddr_width_p, 39, virtual address / PC width
stride_width_p, 8, RPT stride width; the stride is two's-complement signed
prefetch_degree_p, 2, prefetches issued per stride report (≥1)
line_width_p, 512, dcache line size in bits; line address = addr >> log2(line_width_p/8)
rpt_latency_p, 2, cycles from RPT write-valid to stride report

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset; asynchronous assert, active-low
train0_v_i  in  1  load pipe 0 training request
train0_pc_i  in  vaddr_width_p  load PC
train0_eaddr_i  in  vaddr_width_p  load effective address
train0_ready_o  out  1  request 0 accepted this cycle
train1_v_i / train1_pc_i / train1_eaddr_i / train1_ready_o  same as port 0
rpt_init_done_i  in  1  RPT ready to accept training
rpt_w_v_o  out  1  training strobe to RPT
rpt_pc_o  out  vaddr_width_p  granted PC
rpt_eff_addr_o  out  vaddr_width_p  granted effective address
rpt_stride_v_i  in  1  RPT predicts a striding load
rpt_stride_i  in  stride_width_p  predicted stride
flush_i  in  1  abort burst and discard in-flight alignment
pf_v_o  out  1  prefetch request valid
pf_addr_o  out  vaddr_width_p  prefetch byte address
pf_ready_i  in  1  dcache accepts prefetch
busy_o  out  1  burst in progress
drop_cnt_o  out  8  saturating count of stride reports dropped while busy

Behaviour:
- Reset (async, reset_n_i=0):
  - All outputs 0; state e_idle.
  - RR pointer favours port 0.
  - Last-line register invalid; shadow pipe invalid; drop_cnt 0.
- Arbitration (combinational):
  - Nothing is granted while rpt_init_done_i=0.
  - One valid requester: it wins. Both valid: the port not granted last wins.
  - The pointer updates only on a grant.
  - trainN_ready_o = grant to N. rpt_w_v_o = any grant, with rpt_pc_o/rpt_eff_addr_o muxed from the winner.
  - Requesters must not make valid depend on ready.
- Alignment: shadow shift register, depth rpt_latency_p, carries {v, eaddr} of each grant.
  - A stride report is paired with the tail entry.
  - rpt_stride_v_i with tail invalid is ignored.
  - flush_i clears every shadow entry.
- Stride is sign-extended to vaddr_width_p. Address arithmetic is modulo 2^vaddr_width_p (wrap, no error). A zero stride report is ignored.
- FSM:
  - e_idle: on an accepted report (tail valid, stride≠0, no flush) load base=eaddr+stride, remaining=prefetch_degree_p, stride_r; go to e_issue.
  - e_issue:
    - If line(base) equals the valid last line: skip silently (pf_v_o=0), base+=stride, remaining-=1 in one cycle.
    - Otherwise pf_v_o=1, pf_addr_o=base, held stable until pf_ready_i. On handshake: last line←line(base), base+=stride, remaining-=1.
    - remaining reaching 0 → e_idle.
  - flush_i in e_issue: drop pf_v_o next cycle, go to e_idle. A handshake completing in the flush cycle still counts.
  - Report arriving in e_issue: dropped, drop_cnt_o += 1, saturating at 255.
- busy_o = (state==e_issue).
- Training continues independent of FSM state.
- Mid-operation reset: immediate return to reset values; no partial request survives.

Decomposition:
- Shared package bp_be_pkg:
  - state enum bp_be_pf_state_e {e_idle, e_issue}
  - struct bp_be_train_req_s {pc, eaddr}
  - line-offset width constant derived from line_width_p
- Sub-module bp_be_pf_rr_arb2: two-input round-robin arbiter with grant pointer.

Test Plan:
- Hold rpt_init_done_i=0 with both valids high for 10 cycles → no ready, rpt_w_v_o=0. Raise init → port 0 granted first.
- Both ports valid continuously → grants alternate 0,1,0,1; rpt_pc_o tracks the winner each cycle.
- Grant eaddr=0x1000, report stride 0x40 two cycles later, degree 2, pf_ready_i=1 → pf_addr_o 0x1040 then 0x1080; busy_o falls after the second handshake.
- Stride 0x08 from eaddr=0x1000 → first request is 0x1008. Next target 0x1010 shares line 0x40 → skipped with no pf_v_o; burst ends.
- pf_ready_i=0 for 5 cycles with a second report arriving → pf_addr_o stable, drop_cnt_o=1. Stride 0xF0 (−16) from 0x0 → address 0x7F_FFFF_FFF0 (wraps).
- Assert flush_i during a burst and again with a grant in flight → pf_v_o low next cycle; a later stride report for the flushed grant issues nothing. Reset during a burst → all outputs 0 immediately.
